// File: rtl/alu_arbiter.sv
// Round-robin share of one single-cycle alu among NB_REQ requesters; result lands in a
// one-entry tagged buffer one cycle after accept, and a stalled buffer blocks new grants.
module alu_arbiter #(
   parameter int NB_REQ       = 2,
   parameter int XLEN         = 32,
   parameter int NB_OPERATION = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                flush_i,
   input  logic [NB_REQ-1:0]                   req_valid_i,
   input  logic [NB_REQ-1:0][XLEN:0]           req_rs1_i,
   input  logic [NB_REQ-1:0][XLEN:0]           req_rs2_i,
   input  logic [NB_REQ-1:0][NB_OPERATION-1:0] req_cmd_i,
   output logic [NB_REQ-1:0]                   req_ready_o,
   output logic                                alu_en_o,
   output logic [XLEN:0]                       alu_rs1_o,
   output logic [XLEN:0]                       alu_rs2_o,
   output logic [NB_OPERATION-1:0]             alu_cmd_o,
   input  logic [XLEN-1:0]                     alu_data_i,
   output logic                                resp_valid_o,
   output logic [$clog2(NB_REQ)-1:0]           resp_id_o,
   output logic [XLEN-1:0]                     resp_data_o,
   input  logic                                resp_ready_i
);

   localparam int ID_W = $clog2(NB_REQ);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   gnt_idx;
   logic [ID_W-1:0]   cand;
   logic [NB_REQ-1:0] grant;
   logic              gnt_any;
   logic              can_issue;
   int                scan;

   assign can_issue   = ((state == EMPTY) || resp_ready_i) && !flush_i;
   assign req_ready_o = grant;

   // First valid requester at or after rr_ptr, wrapping modulo NB_REQ.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      scan    = 0;
      for (int k = 0; k < NB_REQ; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NB_REQ) scan = scan - NB_REQ;
         cand = ID_W'(scan);
         if (can_issue && !gnt_any && req_valid_i[cand]) begin
            gnt_any     = 1'b1;
            gnt_idx     = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= EMPTY;
      else          state <= state_nxt;
   end

   // Flush wins over everything; a grant always (re)fills the buffer.
   always_comb begin
      state_nxt = state;
      if (flush_i)           state_nxt = EMPTY;
      else if (gnt_any)      state_nxt = FULL;
      else if (resp_ready_i) state_nxt = EMPTY;
   end

   always_comb begin
      resp_valid_o = (state == FULL);
      alu_en_o     = gnt_any;
      alu_rs1_o    = '0;
      alu_rs2_o    = '0;
      alu_cmd_o    = '0;
      if (gnt_any) begin
         alu_rs1_o = req_rs1_i[gnt_idx];
         alu_rs2_o = req_rs2_i[gnt_idx];
         alu_cmd_o = req_cmd_i[gnt_idx];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr      <= '0;
         resp_data_o <= '0;
         resp_id_o   <= '0;
      end else if (gnt_any) begin
         rr_ptr      <= (gnt_idx == ID_W'(NB_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
         resp_data_o <= alu_data_i;
         resp_id_o   <= gnt_idx;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected results queued at issue, checked by a monitor on each result handshake.
module tb_alu_arbiter;

   localparam int NB_REQ = 2;
   localparam int XLEN   = 32;
   localparam int NB_OP  = 4;

   localparam logic [NB_OP-1:0] OP_ADD = 4'b0001;
   localparam logic [NB_OP-1:0] OP_SUB = 4'b0010;
   localparam logic [NB_OP-1:0] OP_SLT = 4'b0100;
   localparam logic [NB_OP-1:0] OP_AND = 4'b1000;

   logic                          clk;
   logic                          reset_n;
   logic                          flush;
   logic [NB_REQ-1:0]             req_valid;
   logic [NB_REQ-1:0][XLEN:0]     req_rs1;
   logic [NB_REQ-1:0][XLEN:0]     req_rs2;
   logic [NB_REQ-1:0][NB_OP-1:0]  req_cmd;
   logic [NB_REQ-1:0]             req_ready;
   logic                          alu_en;
   logic [XLEN:0]                 alu_rs1;
   logic [XLEN:0]                 alu_rs2;
   logic [NB_OP-1:0]              alu_cmd;
   logic [XLEN-1:0]               alu_data;
   logic                          resp_valid;
   logic [0:0]                    resp_id;
   logic [XLEN-1:0]               resp_data;
   logic                          resp_ready;

   typedef struct packed {
      logic [0:0]      id;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   alu_arbiter #(.NB_REQ(NB_REQ), .XLEN(XLEN), .NB_OPERATION(NB_OP)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush_i      (flush),
      .req_valid_i  (req_valid),
      .req_rs1_i    (req_rs1),
      .req_rs2_i    (req_rs2),
      .req_cmd_i    (req_cmd),
      .req_ready_o  (req_ready),
      .alu_en_o     (alu_en),
      .alu_rs1_o    (alu_rs1),
      .alu_rs2_o    (alu_rs2),
      .alu_cmd_o    (alu_cmd),
      .alu_data_i   (alu_data),
      .resp_valid_o (resp_valid),
      .resp_id_o    (resp_id),
      .resp_data_o  (resp_data),
      .resp_ready_i (resp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural alu; operands carry a 33rd sign/extension bit.
   always_comb begin
      alu_data = '0;
      case (alu_cmd)
         OP_ADD:  alu_data = alu_rs1[XLEN-1:0] + alu_rs2[XLEN-1:0];
         OP_SUB:  alu_data = alu_rs1[XLEN-1:0] - alu_rs2[XLEN-1:0];
         OP_SLT:  alu_data = {{(XLEN-1){1'b0}}, ($signed(alu_rs1) < $signed(alu_rs2))};
         OP_AND:  alu_data = alu_rs1[XLEN-1:0] & alu_rs2[XLEN-1:0];
         default: alu_data = '0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && resp_valid && resp_ready && !flush) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 64'(resp_data), 64'hDEAD);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_id", 64'(resp_id), 64'(e.id));
            check("resp_data", 64'(resp_data), 64'(e.data));
         end
      end
   end

   task automatic drive(input logic [1:0] v,
                        input logic [XLEN:0] a0, input logic [XLEN:0] b0, input logic [NB_OP-1:0] c0,
                        input logic [XLEN:0] a1, input logic [XLEN:0] b1, input logic [NB_OP-1:0] c1,
                        input logic rr, input logic fl);
      @(posedge clk);
      #1;
      req_valid  = v;
      req_rs1[0] = a0;
      req_rs2[0] = b0;
      req_cmd[0] = c0;
      req_rs1[1] = a1;
      req_rs2[1] = b1;
      req_cmd[1] = c1;
      resp_ready = rr;
      flush      = fl;
   endtask

   task automatic push(input logic [0:0] id, input logic [XLEN-1:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic idle(input logic rr);
      drive(2'b00, '0, '0, '0, '0, '0, '0, rr, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      int a0;
      int a1;
      reset_n   = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_rs1   = '0;
      req_rs2   = '0;
      req_cmd   = '0;
      resp_ready = 1'b0;
      #2;
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_data", 64'(resp_data), 64'd0);
      check("rst_resp_id", 64'(resp_id), 64'd0);
      check("rst_alu_en", 64'(alu_en), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: single ADD from req0, result visible next cycle
      drive(2'b01, 33'd5, 33'd7, OP_ADD, '0, '0, '0, 1'b1, 1'b0);
      push(1'b0, 32'd12);
      @(negedge clk);
      check("t1_ready", 64'(req_ready), 64'b01);
      check("t1_alu_en", 64'(alu_en), 64'd1);
      check("t1_alu_rs1", 64'(alu_rs1), 64'd5);
      check("t1_alu_cmd", 64'(alu_cmd), 64'(OP_ADD));

      // rr_ptr is 1 now; a lone req1 brings it back to 0
      drive(2'b10, '0, '0, '0, 33'd1, 33'd1, OP_ADD, 1'b1, 1'b0);
      push(1'b1, 32'd2);
      @(negedge clk);
      check("t1_resp_valid", 64'(resp_valid), 64'd1);
      check("t1b_ready", 64'(req_ready), 64'b10);

      // 2: both requesters always valid -> alternate 0,1,0,1
      a0 = 0;
      a1 = 0;
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 33'(100 + a0), 33'd1, OP_ADD, 33'(200 + a1), 33'd2, OP_ADD, 1'b1, 1'b0);
         if (k % 2 == 0) push(1'b0, 32'(101 + a0));
         else            push(1'b1, 32'(202 + a1));
         @(negedge clk);
         check("t2_ready", 64'(req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
         if (k % 2 == 0) a0++;
         else            a1++;
      end
      idle(1'b1);

      // 3: stalled FULL buffer holds 0xF0 and blocks req1
      drive(2'b01, 33'hF0, 33'd0, OP_ADD, '0, '0, '0, 1'b0, 1'b0);
      push(1'b0, 32'hF0);
      @(negedge clk);
      check("t3_fill_ready", 64'(req_ready), 64'b01);
      for (int k = 0; k < 3; k++) begin
         drive(2'b10, '0, '0, '0, 33'h30, 33'h3, OP_SUB, 1'b0, 1'b0);
         @(negedge clk);
         check("t3_stall_ready", 64'(req_ready), 64'b00);
         check("t3_stall_valid", 64'(resp_valid), 64'd1);
         check("t3_stall_data", 64'(resp_data), 64'hF0);
      end
      drive(2'b10, '0, '0, '0, 33'h30, 33'h3, OP_SUB, 1'b1, 1'b0);
      push(1'b1, 32'h2D);
      @(negedge clk);
      check("t3_replace_ready", 64'(req_ready), 64'b10);

      // 4: ADD wraps to 0; SLT with extension bit set treats rs1 as negative
      drive(2'b10, '0, '0, '0, 33'h0_FFFF_FFFF, 33'h0_0000_0001, OP_ADD, 1'b1, 1'b0);
      push(1'b1, 32'd0);
      @(negedge clk);
      check("t4_add_ready", 64'(req_ready), 64'b10);
      drive(2'b10, '0, '0, '0, 33'h1_FFFF_FFFF, 33'h0_0000_0001, OP_SLT, 1'b1, 1'b0);
      push(1'b1, 32'd1);
      @(negedge clk);
      check("t4_slt_ready", 64'(req_ready), 64'b10);
      idle(1'b1);

      // 5: flush drops FULL buffer, blocks grant, keeps rr_ptr at 1
      drive(2'b01, 33'd3, 33'd4, OP_ADD, '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      check("t5_fill_ready", 64'(req_ready), 64'b01);
      drive(2'b01, 33'd3, 33'd4, OP_ADD, '0, '0, '0, 1'b1, 1'b1);
      @(negedge clk);
      check("t5_flush_ready", 64'(req_ready), 64'b00);
      check("t5_flush_alu_en", 64'(alu_en), 64'd0);
      check("t5_flush_alu_rs1", 64'(alu_rs1), 64'd0);
      drive(2'b11, 33'd3, 33'd4, OP_ADD, 33'd9, 33'd1, OP_AND, 1'b1, 1'b0);
      push(1'b1, 32'd1);
      @(negedge clk);
      check("t5_post_valid", 64'(resp_valid), 64'd0);
      check("t5_post_ready", 64'(req_ready), 64'b10);
      idle(1'b1);

      // 6: async reset while FULL with rr_ptr=1
      drive(2'b01, 33'd2, 33'd2, OP_ADD, '0, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      drive(2'b00, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
      #2;
      check("t6_pre_valid", 64'(resp_valid), 64'd1);
      reset_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(resp_valid), 64'd0);
      check("t6_rst_data", 64'(resp_data), 64'd0);
      check("t6_rst_id", 64'(resp_id), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(2'b11, 33'd6, 33'd6, OP_ADD, 33'd1, 33'd1, OP_SUB, 1'b1, 1'b0);
      push(1'b0, 32'd12);
      @(negedge clk);
      check("t6_first_ready", 64'(req_ready), 64'b01);
      idle(1'b1);

      for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1'b1);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
